// File: rtl/uart_pkg.sv
// Shared constants, FSM encodings and the baud divisor calculation for the UART link.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PAR,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PAR,
    RX_STOP
  } rx_state_t;

  // Clocks per oversample tick, rounded to nearest.
  function automatic int calc_div(input int clk_hz, input int baud, input int os);
    int den;
    den = baud * os;
    return (clk_hz + den / 2) / den;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// First-word-fall-through FIFO with occupancy; writes while full are dropped.
module uart_fifo #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] wr_data,
  input  logic          wr_en,
  output logic          full,
  output logic [DW-1:0] rd_data,
  input  logic          rd_en,
  output logic          empty,
  output logic [AW:0]   level
);

  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [DW-1:0] mem [2**AW];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          push, pop;

  // Pointers carry one extra wrap bit, so the difference is the fill level.
  assign level   = wr_ptr - rd_ptr;
  assign full    = level[AW];
  assign empty   = (level == '0);
  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // Pointer update; push and pop may happen together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage needs no reset; only slots below the level are ever read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/uart_stream_link.sv
// Full-duplex UART: stream ports in/out through FIFOs, shared oversample tick, sticky errors.
module uart_stream_link
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_AW    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic                 tx,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic [FIFO_AW:0]     tx_level,
  output logic [FIFO_AW:0]     rx_level,
  output logic                 tx_busy,
  output logic                 err_frame,
  output logic                 err_parity,
  output logic                 err_overrun,
  input  logic                 err_clr
);

  localparam int DIV   = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OS_W  = $clog2(OVERSAMPLE);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0]  OS_HALF  = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0]  OS_ONE   = OS_W'(1);
  localparam logic [3:0]       DB_LAST  = 4'(DATA_BITS - 1);
  localparam logic [3:0]       SB_LAST  = 4'(STOP_BITS - 1);
  localparam logic [3:0]       BC_ONE   = 4'd1;

  if (DIV < 1) begin : g_div_chk
    $error("uart_stream_link: CLK_HZ too low for BAUD*OVERSAMPLE");
  end
  if (OVERSAMPLE < 8 || OVERSAMPLE % 2 != 0 || DATA_BITS < 5 || DATA_BITS > 9 ||
      PARITY > PAR_EVEN || STOP_BITS < 1 || STOP_BITS > 2) begin : g_par_chk
    $error("uart_stream_link: unsupported frame parameters");
  end

  // ---------------- tick ----------------
  logic [DIV_W-1:0] div_cnt;
  logic             tick;

  assign tick = (div_cnt == DIV_LAST);

  // Free-running divisor; tick is high for the last count of every period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) div_cnt <= '0;
    else     div_cnt <= tick ? '0 : div_cnt + DIV_ONE;
  end

  // ---------------- FIFOs ----------------
  logic [DATA_BITS-1:0] tx_head, rx_sh;
  logic                 tx_full, tx_empty, tx_pop;
  logic                 rx_full, rx_empty, rx_push;

  uart_fifo #(.DW(DATA_BITS), .AW(FIFO_AW)) u_tx_fifo (
    .clk(clk), .rst(rst),
    .wr_data(tx_data), .wr_en(tx_valid), .full(tx_full),
    .rd_data(tx_head), .rd_en(tx_pop), .empty(tx_empty),
    .level(tx_level)
  );

  uart_fifo #(.DW(DATA_BITS), .AW(FIFO_AW)) u_rx_fifo (
    .clk(clk), .rst(rst),
    .wr_data(rx_sh), .wr_en(rx_push), .full(rx_full),
    .rd_data(rx_data), .rd_en(rx_ready), .empty(rx_empty),
    .level(rx_level)
  );

  assign tx_ready = !tx_full;
  assign rx_valid = !rx_empty;

  // ---------------- TX ----------------
  tx_state_t            tx_state, tx_state_n;
  logic [OS_W-1:0]      tx_os, tx_os_n;
  logic [3:0]           tx_bit, tx_bit_n;
  logic [DATA_BITS-1:0] tx_sh, tx_sh_n;
  logic                 tx_par, tx_par_n, tx_line, tx_q, tx_bit_end;

  assign tx_bit_end = tick && (tx_os == OS_LAST);
  assign tx_busy    = (tx_state != TX_IDLE);
  assign tx         = tx_q;

  // TX state and line register; tx is registered so it lags the state by one clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_os    <= '0;
      tx_bit   <= '0;
      tx_sh    <= '0;
      tx_par   <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_os    <= tx_os_n;
      tx_bit   <= tx_bit_n;
      tx_sh    <= tx_sh_n;
      tx_par   <= tx_par_n;
      tx_q     <= tx_line;
    end
  end

  // TX sequencing; a new frame is loaded from IDLE or straight out of the last stop bit.
  always_comb begin
    tx_state_n = tx_state;
    tx_os_n    = tx_os;
    tx_bit_n   = tx_bit;
    tx_sh_n    = tx_sh;
    tx_par_n   = tx_par;
    tx_pop     = 1'b0;
    if (tx_state != TX_IDLE && tick) tx_os_n = tx_bit_end ? '0 : tx_os + OS_ONE;
    case (tx_state)
      TX_IDLE:  tx_pop = !tx_empty;
      TX_START: if (tx_bit_end) begin
        tx_state_n = TX_DATA;
        tx_bit_n   = '0;
      end
      TX_DATA:  if (tx_bit_end) begin
        tx_sh_n = tx_sh >> 1;
        if (tx_bit == DB_LAST) begin
          tx_state_n = (PARITY != PAR_NONE) ? TX_PAR : TX_STOP;
          tx_bit_n   = '0;
        end else begin
          tx_bit_n = tx_bit + BC_ONE;
        end
      end
      TX_PAR:   if (tx_bit_end) begin
        tx_state_n = TX_STOP;
        tx_bit_n   = '0;
      end
      TX_STOP:  if (tx_bit_end) begin
        if (tx_bit == SB_LAST) begin
          tx_state_n = TX_IDLE;
          tx_pop     = !tx_empty;
        end else begin
          tx_bit_n = tx_bit + BC_ONE;
        end
      end
      default:  tx_state_n = TX_IDLE;
    endcase
    if (tx_pop) begin
      tx_state_n = TX_START;
      tx_sh_n    = tx_head;
      tx_par_n   = (PARITY == PAR_ODD) ? ~^tx_head : ^tx_head;
      tx_os_n    = '0;
      tx_bit_n   = '0;
    end
  end

  // Line level for the current TX state.
  always_comb begin
    tx_line = 1'b1;
    case (tx_state)
      TX_START: tx_line = 1'b0;
      TX_DATA:  tx_line = tx_sh[0];
      TX_PAR:   tx_line = tx_par;
      default:  tx_line = 1'b1;
    endcase
  end

  // ---------------- RX ----------------
  rx_state_t            rx_state, rx_state_n;
  logic [OS_W-1:0]      rx_os, rx_os_n;
  logic [3:0]           rx_bit, rx_bit_n;
  logic [DATA_BITS-1:0] rx_sh_n;
  logic                 rx_pbit, rx_pbit_n;
  logic                 rx_s1, rx_s2, rx_prev, rx_fall, rx_sample, par_bad;
  logic                 set_frame, set_par, set_ovr;

  assign rx_fall   = rx_prev && !rx_s2;
  assign rx_sample = tick && (rx_os == OS_LAST);
  assign par_bad   = (PARITY == PAR_ODD)  ? !(^{rx_sh, rx_pbit}) :
                     (PARITY == PAR_EVEN) ?  (^{rx_sh, rx_pbit}) : 1'b0;

  // Synchroniser, edge detect history and RX state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_os    <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
      rx_pbit  <= 1'b0;
    end else begin
      rx_s1    <= rx;
      rx_s2    <= rx_s1;
      rx_prev  <= rx_s2;
      rx_state <= rx_state_n;
      rx_os    <= rx_os_n;
      rx_bit   <= rx_bit_n;
      rx_sh    <= rx_sh_n;
      rx_pbit  <= rx_pbit_n;
    end
  end

  // RX sequencing: centre on the start bit, then sample one full bit period apart.
  always_comb begin
    rx_state_n = rx_state;
    rx_os_n    = rx_os;
    rx_bit_n   = rx_bit;
    rx_sh_n    = rx_sh;
    rx_pbit_n  = rx_pbit;
    rx_push    = 1'b0;
    set_frame  = 1'b0;
    set_par    = 1'b0;
    set_ovr    = 1'b0;
    if (rx_state != RX_IDLE && tick) rx_os_n = rx_sample ? '0 : rx_os + OS_ONE;
    case (rx_state)
      RX_IDLE:  if (rx_fall) begin
        rx_state_n = RX_START;
        rx_os_n    = '0;
      end
      RX_START: if (tick && rx_os == OS_HALF) begin
        rx_os_n    = '0;
        rx_bit_n   = '0;
        rx_state_n = rx_s2 ? RX_IDLE : RX_DATA;
      end
      RX_DATA:  if (rx_sample) begin
        rx_sh_n = {rx_s2, rx_sh[DATA_BITS-1:1]};
        if (rx_bit == DB_LAST) rx_state_n = (PARITY != PAR_NONE) ? RX_PAR : RX_STOP;
        else                   rx_bit_n   = rx_bit + BC_ONE;
      end
      RX_PAR:   if (rx_sample) begin
        rx_pbit_n  = rx_s2;
        rx_state_n = RX_STOP;
      end
      RX_STOP:  if (rx_sample) begin
        // Only the first stop bit is checked; any second one is just idle line.
        rx_state_n = RX_IDLE;
        set_frame  = !rx_s2;
        set_par    = par_bad;
        if (rx_s2 && !par_bad) begin
          if (rx_full) set_ovr = 1'b1;
          else         rx_push = 1'b1;
        end
      end
      default:  rx_state_n = RX_IDLE;
    endcase
  end

  // Sticky errors; a new error beats a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_frame   <= 1'b0;
      err_parity  <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      err_frame   <= set_frame | (err_frame   & ~err_clr);
      err_parity  <= set_par   | (err_parity  & ~err_clr);
      err_overrun <= set_ovr   | (err_overrun & ~err_clr);
    end
  end

endmodule

// File: tb/tb_uart_stream_link.sv
// Directed bench: 8N1 instance for TX/RX/overrun/reset, 8E1 instance for parity cases.
module tb_uart_stream_link;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       rx, tx, tx_valid, tx_ready, rx_valid, rx_ready, tx_busy;
  logic       err_frame, err_parity, err_overrun, err_clr;
  logic [7:0] tx_data, rx_data;
  logic [4:0] tx_level, rx_level;

  logic       rx_p, tx_p, tx_valid_p, tx_ready_p, rx_valid_p, tx_busy_p;
  logic       err_frame_p, err_parity_p, err_overrun_p;
  logic [7:0] tx_data_p, rx_data_p;
  logic [4:0] tx_level_p, rx_level_p;

  uart_stream_link #(
    .CLK_HZ(1_600_000), .BAUD(100_000), .OVERSAMPLE(16), .DATA_BITS(8),
    .PARITY(0), .STOP_BITS(1), .FIFO_AW(4)
  ) dut (
    .clk(clk), .rst(rst), .rx(rx), .tx(tx),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_level(tx_level), .rx_level(rx_level), .tx_busy(tx_busy),
    .err_frame(err_frame), .err_parity(err_parity), .err_overrun(err_overrun),
    .err_clr(err_clr)
  );

  uart_stream_link #(
    .CLK_HZ(1_600_000), .BAUD(100_000), .OVERSAMPLE(16), .DATA_BITS(8),
    .PARITY(2), .STOP_BITS(1), .FIFO_AW(4)
  ) dut_p (
    .clk(clk), .rst(rst), .rx(rx_p), .tx(tx_p),
    .tx_data(tx_data_p), .tx_valid(tx_valid_p), .tx_ready(tx_ready_p),
    .rx_data(rx_data_p), .rx_valid(rx_valid_p), .rx_ready(rx_ready),
    .tx_level(tx_level_p), .rx_level(rx_level_p), .tx_busy(tx_busy_p),
    .err_frame(err_frame_p), .err_parity(err_parity_p), .err_overrun(err_overrun_p),
    .err_clr(err_clr)
  );

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;   // line bits, bit 0 = start bit
  } tx_vec_t;

  typedef struct {
    bit         sel;     // 1: parity instance
    logic [11:0] bits;   // line bits, bit 0 = start bit
    int         n;
    int         skew;    // start bit length offset in clocks
    bit         ev;
    logic [7:0] ed;
    bit         ef;
    bit         ep;
  } rx_vec_t;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_rx(input bit sel, input logic [11:0] bits, input int n, input int skew);
    for (int i = 0; i < n; i++) begin
      if (sel) rx_p = bits[i];
      else     rx   = bits[i];
      step((i == 0) ? 16 + skew : 16);
    end
    rx   = 1'b1;
    rx_p = 1'b1;
    step(8);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    tx_vec_t     tv[3];
    rx_vec_t     rv[7];
    logic [29:0] b2b;
    logic        gv, gf, gp, go;
    logic [7:0]  gd;
    logic [4:0]  gl;
    logic [7:0]  d;

    tv[0] = '{8'hA5, 10'b1_10100101_0};
    tv[1] = '{8'h81, 10'b1_10000001_0};
    tv[2] = '{8'h3C, 10'b1_00111100_0};

    rv[0] = '{1'b0, 12'b00_1_01011010_0, 10, -4, 1'b1, 8'h5A, 1'b0, 1'b0};
    rv[1] = '{1'b0, 12'b00_1_11000011_0, 10,  4, 1'b1, 8'hC3, 1'b0, 1'b0};
    rv[2] = '{1'b0, 12'b00_0_00000000_0, 10,  0, 1'b0, 8'h00, 1'b1, 1'b0};
    rv[3] = '{1'b1, 12'b0_1_0_00000111_0, 11, 0, 1'b0, 8'h00, 1'b0, 1'b1};
    rv[4] = '{1'b1, 12'b0_1_1_00000111_0, 11, 0, 1'b1, 8'h07, 1'b0, 1'b0};
    rv[5] = '{1'b1, 12'b0_1_0_00000011_0, 11, 0, 1'b1, 8'h03, 1'b0, 1'b0};
    rv[6] = '{1'b1, 12'b0_0_1_00000011_0, 11, 0, 1'b0, 8'h00, 1'b1, 1'b1};

    rst = 1'b1; rx = 1'b1; rx_p = 1'b1; tx_valid = 1'b0; tx_data = '0;
    rx_ready = 1'b0; err_clr = 1'b0; tx_valid_p = 1'b0; tx_data_p = '0;
    step(3);
    rst = 1'b0;
    step(2);

    // reset state
    chk("rst_tx", tx, 1);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_tx_level", tx_level, 0);
    chk("rst_rx_level", rx_level, 0);
    chk("rst_busy", tx_busy, 0);
    chk("rst_errs", {err_frame, err_parity, err_overrun}, 0);

    // single TX frames, checked every clock
    for (int i = 0; i < 3; i++) begin
      tx_data = tv[i].data; tx_valid = 1'b1;
      step(1);                                  // accept edge
      tx_valid = 1'b0;
      chk($sformatf("tx%0d_lvl_acc", i), tx_level, 1);
      chk($sformatf("tx%0d_idle_e0", i), tx, 1);
      step(1);
      chk($sformatf("tx%0d_idle_e1", i), tx, 1);
      chk($sformatf("tx%0d_busy_e1", i), tx_busy, 1);
      chk($sformatf("tx%0d_lvl_pop", i), tx_level, 0);
      step(1);                                  // tx falls here
      for (int c = 0; c < 160; c++) begin
        chk($sformatf("tx%0d_bit_c%0d", i, c), tx, tv[i].frame[c / 16]);
        if (c == 158) chk($sformatf("tx%0d_busy_end", i), tx_busy, 1);
        step(1);
      end
      chk($sformatf("tx%0d_busy_done", i), tx_busy, 0);
      chk($sformatf("tx%0d_idle_after", i), tx, 1);
      step(5);
    end

    // back-to-back: 0x00, 0xFF, 0x3C with no idle gap
    b2b = {10'b1_00111100_0, 10'b1_11111111_0, 10'b1_00000000_0};
    tx_valid = 1'b1;
    tx_data = 8'h00; step(1);
    tx_data = 8'hFF; step(1);
    tx_data = 8'h3C; step(1);
    tx_valid = 1'b0;
    chk("b2b_lvl_start", tx_level, 2);
    for (int c = 0; c < 480; c++) begin
      chk($sformatf("b2b_bit_c%0d", c), tx, b2b[c / 16]);
      if (c == 168) chk("b2b_lvl_mid", tx_level, 1);
      if (c == 328) chk("b2b_lvl_last", tx_level, 0);
      step(1);
    end
    chk("b2b_busy_done", tx_busy, 0);
    chk("b2b_idle", tx, 1);

    // RX table, both instances
    for (int i = 0; i < 7; i++) begin
      send_rx(rv[i].sel, rv[i].bits, rv[i].n, rv[i].skew);
      gv = rv[i].sel ? rx_valid_p    : rx_valid;
      gd = rv[i].sel ? rx_data_p     : rx_data;
      gl = rv[i].sel ? rx_level_p    : rx_level;
      gf = rv[i].sel ? err_frame_p   : err_frame;
      gp = rv[i].sel ? err_parity_p  : err_parity;
      go = rv[i].sel ? err_overrun_p : err_overrun;
      chk($sformatf("rx%0d_valid", i), gv, rv[i].ev);
      chk($sformatf("rx%0d_level", i), gl, rv[i].ev ? 1 : 0);
      if (rv[i].ev) chk($sformatf("rx%0d_data", i), gd, rv[i].ed);
      chk($sformatf("rx%0d_err_frame", i), gf, rv[i].ef);
      chk($sformatf("rx%0d_err_parity", i), gp, rv[i].ep);
      chk($sformatf("rx%0d_err_overrun", i), go, 0);
      if (gv) begin
        rx_ready = 1'b1; step(1); rx_ready = 1'b0;
        chk($sformatf("rx%0d_popped", i), rv[i].sel ? rx_level_p : rx_level, 0);
      end
      if (rv[i].ef || rv[i].ep) begin
        err_clr = 1'b1;
        #1;
        chk($sformatf("rx%0d_clr_hold", i), rv[i].sel ? {err_frame_p, err_parity_p}
                                                       : {err_frame, err_parity},
            {rv[i].ef, rv[i].ep});
        step(1);
        err_clr = 1'b0;
        chk($sformatf("rx%0d_clr_done", i), rv[i].sel ? {err_frame_p, err_parity_p}
                                                       : {err_frame, err_parity}, 0);
      end
    end

    // 2-clock glitch is a false start
    rx = 1'b0; step(2); rx = 1'b1; step(40);
    chk("glitch_level", rx_level, 0);
    chk("glitch_errs", {err_frame, err_parity, err_overrun}, 0);

    // overrun: 17 bytes, no pops
    for (int i = 0; i < 17; i++) begin
      d = 8'(i * 29 + 3);
      send_rx(1'b0, {3'b001, d, 1'b0}, 10, 0);
      if (i == 15) begin
        chk("ovr_lvl_full", rx_level, 16);
        chk("ovr_not_yet", err_overrun, 0);
      end
    end
    chk("ovr_level", rx_level, 16);
    chk("ovr_flag", err_overrun, 1);
    chk("ovr_frame_ok", err_frame, 0);
    for (int i = 0; i < 16; i++) begin
      d = 8'(i * 29 + 3);
      chk($sformatf("ovr_data%0d", i), rx_data, d);
      rx_ready = 1'b1; step(1); rx_ready = 1'b0;
    end
    chk("ovr_drained", rx_valid, 0);
    err_clr = 1'b1; step(1); err_clr = 1'b0;
    chk("ovr_clr", err_overrun, 0);

    // reset in the middle of a TX frame with RX data queued
    send_rx(1'b0, 12'b00_1_01011010_0, 10, 0);
    chk("mid_rx_level", rx_level, 1);
    tx_valid = 1'b1;
    tx_data = 8'h55; step(1);
    tx_data = 8'h0F; step(1);
    tx_valid = 1'b0;
    step(5);
    chk("mid_tx_low", tx, 0);
    chk("mid_tx_level", tx_level, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_tx", tx, 1);
    chk("mid_rst_busy", tx_busy, 0);
    chk("mid_rst_tx_level", tx_level, 0);
    chk("mid_rst_rx_level", rx_level, 0);
    step(2);
    rst = 1'b0;
    step(200);
    chk("post_rst_tx", tx, 1);
    chk("post_rst_busy", tx_busy, 0);
    chk("post_rst_errs", {err_frame, err_parity, err_overrun}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
